md_unit: RTL and testbench



---
 rtl/md_unit.sv | 91 +++++++++
 tb/tb_md_unit.sv | 139 +++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO register pair.
// Ports: clk (rising edge), reset (async, active-low), MDctrl (3-bit op),
//        A/B (forwarded rs/rt), HILOsel (1=HI, 0=LO), Start (comb issue),
//        Busy (registered, op in flight), HILO_out (comb HI/LO read).
// Optional feature: define MDU_MADD_EN to enable MDctrl=111 signed madd.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  MDctrl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HILOsel,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HILO_out
);
    localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;
    logic [31:0] hi, lo;
    logic [CW-1:0] cnt;
    logic [63:0] res, res_q;
    logic wr_q;
    logic is_mul, is_div, is_mac;
    logic [63:0] smul, umul;
    logic [31:0] sdvs, udvs, squot, srem, uquot, urem;
    assign is_mul = MDctrl == 3'b001 || MDctrl == 3'b010;
    assign is_div = MDctrl == 3'b011 || MDctrl == 3'b100;
`ifdef MDU_MADD_EN
    assign is_mac = MDctrl == 3'b111;
`else
    assign is_mac = 1'b0;
`endif
    assign Start = (is_mul || is_div || is_mac) && !Busy;
    assign HILO_out = HILOsel ? hi : lo;
    assign smul = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign umul = {32'd0, A} * {32'd0, B};
    // Divisor 1 stands in for both divide-by-zero (result discarded) and
    // 0x80000000 / -1, where A / 1 gives exactly the required LO and HI=0.
    assign sdvs = (B == 32'd0 || (A == 32'h8000_0000 && B == 32'hFFFF_FFFF)) ? 32'd1 : B;
    assign udvs = B == 32'd0 ? 32'd1 : B;
    assign squot = $signed(A) / $signed(sdvs);
    assign srem = $signed(A) % $signed(sdvs);
    assign uquot = A / udvs;
    assign urem = A % udvs;
    always_comb begin
        res = MDctrl == 3'b001 ? smul :
              MDctrl == 3'b010 ? umul :
              MDctrl == 3'b011 ? {srem, squot} :
              MDctrl == 3'b100 ? {urem, uquot} :
`ifdef MDU_MADD_EN
              {hi, lo} + smul;
`else
              64'd0;
`endif
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            res_q <= '0;
            wr_q  <= 1'b0;
        end else if (state == IDLE) begin
            if (Start) begin
                state <= BUSY;
                Busy  <= 1'b1;
                cnt   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                res_q <= res;
                wr_q  <= !(is_div && B == 32'd0);
            end else if (MDctrl == 3'b101) begin
                hi <= A;
            end else if (MDctrl == 3'b110) begin
                lo <= A;
            end
        end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state <= IDLE;
                Busy  <= 1'b0;
                if (wr_q) {hi, lo} <= res_q;
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed table-driven bench for md_unit plus corner sequences.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  MDctrl = 3'b000;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        HILOsel = 1'b0;
    logic        Start, Busy;
    logic [31:0] HILO_out;
    int n_cmp = 0;
    int n_err = 0;
    md_unit dut (
        .clk(clk), .reset(reset), .MDctrl(MDctrl), .A(A), .B(B),
        .HILOsel(HILOsel), .Start(Start), .Busy(Busy), .HILO_out(HILO_out)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        st;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t tbl[15];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic rd(output logic [31:0] h, output logic [31:0] l);
        HILOsel = 1'b1;
        #1 h = HILO_out;
        HILOsel = 1'b0;
        #1 l = HILO_out;
    endtask
    task automatic wait_idle(inout int n);
        while (Busy && n < 60) begin
            @(posedge clk);
            #1 n++;
        end
        MDctrl = 3'b000;
    endtask
    initial begin
        logic [31:0] h, l;
        int n;
        tbl[0]  = '{3'b001, 32'hFFFF_FFFE, 32'd3,         1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        tbl[1]  = '{3'b010, 32'hFFFF_FFFE, 32'd3,         1'b1, 5,  32'h0000_0002, 32'hFFFF_FFFA};
        tbl[2]  = '{3'b011, 32'hFFFF_FFF9, 32'd2,         1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3]  = '{3'b100, 32'd7,         32'd0,         1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[4]  = '{3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10, 32'h0000_0000, 32'h8000_0000};
        tbl[5]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10, 32'h8000_0000, 32'h0000_0000};
        tbl[6]  = '{3'b011, 32'd7,         32'hFFFF_FFFE, 1'b1, 10, 32'h0000_0001, 32'hFFFF_FFFD};
        tbl[7]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 1'b1, 5,  32'h4000_0000, 32'h0000_0000};
        tbl[8]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5,  32'hFFFF_FFFE, 32'h0000_0001};
        tbl[9]  = '{3'b101, 32'h1234_5678, 32'd0,         1'b0, 0,  32'h1234_5678, 32'h0000_0001};
        tbl[10] = '{3'b110, 32'hCAFE_F00D, 32'd0,         1'b0, 0,  32'h1234_5678, 32'hCAFE_F00D};
        tbl[11] = '{3'b011, 32'd5,         32'd0,         1'b1, 10, 32'h1234_5678, 32'hCAFE_F00D};
        tbl[12] = '{3'b110, 32'd5,         32'd0,         1'b0, 0,  32'h1234_5678, 32'h0000_0005};
        tbl[13] = '{3'b101, 32'd0,         32'd0,         1'b0, 0,  32'h0000_0000, 32'h0000_0005};
`ifdef MDU_MADD_EN
        tbl[14] = '{3'b111, 32'd2,         32'd3,         1'b1, 5,  32'h0000_0000, 32'h0000_000B};
`else
        tbl[14] = '{3'b111, 32'd2,         32'd3,         1'b0, 0,  32'h0000_0000, 32'h0000_0005};
`endif
        #12;
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_start", {31'd0, Start}, 32'd0);
        rd(h, l);
        chk("reset_hi", h, 32'd0);
        chk("reset_lo", l, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            MDctrl = tbl[i].op;
            A = tbl[i].a;
            B = tbl[i].b;
            #1 chk($sformatf("v%0d_start", i), {31'd0, Start}, {31'd0, tbl[i].st});
            @(posedge clk);
            #1 MDctrl = 3'b000;
            n = 0;
            wait_idle(n);
            chk($sformatf("v%0d_busy_cycles", i), n, tbl[i].cyc);
            rd(h, l);
            chk($sformatf("v%0d_hi", i), h, tbl[i].hi);
            chk($sformatf("v%0d_lo", i), l, tbl[i].lo);
        end
        // mult in flight: a div on busy cycle 2 and an mthi on cycle 3 are ignored
        @(negedge clk);
        MDctrl = 3'b001;
        A = 32'd5;
        B = 32'd6;
        @(posedge clk);
        #1 MDctrl = 3'b000;
        n = 0;
        @(posedge clk);
        #1 n++;
        MDctrl = 3'b011;
        A = 32'd100;
        B = 32'd3;
        #1 chk("busy_div_start", {31'd0, Start}, 32'd0);
        @(posedge clk);
        #1 n++;
        MDctrl = 3'b101;
        A = 32'hDEAD_BEEF;
        wait_idle(n);
        chk("ovl_busy_cycles", n, 5);
        rd(h, l);
        chk("ovl_hi", h, 32'd0);
        chk("ovl_lo", l, 32'd30);
        // asynchronous reset in busy cycle 4 of a div
        @(negedge clk);
        MDctrl = 3'b011;
        A = 32'd100;
        B = 32'd3;
        @(posedge clk);
        #1 MDctrl = 3'b000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1 chk("rst_busy", {31'd0, Busy}, 32'd0);
        rd(h, l);
        chk("rst_hi", h, 32'd0);
        chk("rst_lo", l, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1 chk("post_rst_busy", {31'd0, Busy}, 32'd0);
        rd(h, l);
        chk("post_rst_hi", h, 32'd0);
        chk("post_rst_lo", l, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
